pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the five-stage pipeline. It takes hazard sources from Decode, Execute and the memories (load-use, taken branch/jump, data-memory stall, instruction-memory stall, halt) and drives the write-enable, flush and redirect controls for the PC, F/D and D/E registers. The E/M hold on DataMemStall stays local to Execute; this block freezes everything upstream of it. It also owns halt draining and two saturating performance counters.

Parameters:
DRAIN_CYCLES, 3, cycles after halt leaves Decode before Halted asserts (E, M, W)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
Rs_D  in  3  Decode source reg 1
RsV_D  in  1  Rs_D valid
Rt_D  in  3  Decode source reg 2
RtV_D  in  1  Rt_D valid
Halt_D  in  1  halt instruction in Decode
MemRead_E  in  1  Execute instruction is a load
WriteReg_E  in  3  Execute destination reg
WriteRegEn_E  in  1  Execute writes register
BranchEF  in  1  taken branch resolved in Execute
Jump_E  in  1  jump in Execute
DataMemStall  in  1  data memory busy
InstMemStall  in  1  instruction fetch not complete
PCWriteEn  out  1  PC register update enable
Redirect  out  1  PC mux selects Execute NextPC
FD_WriteEn  out  1  F/D register enable
FD_Flush  out  1  F/D loads NOP
DE_WriteEn  out  1  D/E register enable
DE_Flush  out  1  D/E loads NOP
Halted  out  1  pipeline fully drained after halt
StallCycles  out  CNT_W  stall cycle count
FlushCount  out  CNT_W  redirect count

Behaviour:
- States: RUN, PEND (redirect while fetch outstanding), DRAIN, HALTED. Registered: state, drain counter, StallCycles, FlushCount. Control outputs are combinational from state and current inputs.
- rst=1 (any state, mid-operation included): next state RUN, counters 0. During the rst cycle: PCWriteEn=FD_WriteEn=DE_WriteEn=0, FD_Flush=DE_Flush=1, Redirect=0, Halted=0.
- Definitions: redir = BranchEF | Jump_E. loaduse = MemRead_E & WriteRegEn_E & ((RsV_D & Rs_D==WriteReg_E) | (RtV_D & Rt_D==WriteReg_E)).
- Default for all enables is 1; flushes and Redirect default to 0.
- RUN, first matching rule applies:
  1. DataMemStall: PCWriteEn=FD_WriteEn=DE_WriteEn=0, no flush, redir ignored (E is frozen and re-presents it). StallCycles++.
  2. redir: Redirect=1, PCWriteEn=1, FD_Flush=1, DE_Flush=1, FlushCount++. If InstMemStall is also set, next state is PEND.
  3. loaduse: PCWriteEn=0, FD_WriteEn=0, DE_Flush=1 (one bubble). Next cycle the load is in M, so the condition clears. StallCycles++.
  4. InstMemStall: PCWriteEn=0, FD_Flush=1 (bubble into D). StallCycles++.
  5. Halt_D: PCWriteEn=0, FD_Flush=1, drain counter set to DRAIN_CYCLES, next state DRAIN.
  6. Otherwise all enables 1.
- PEND (wrong-path fetch outstanding): PCWriteEn=0, FD_Flush=1 every cycle.
  - DataMemStall additionally forces FD_WriteEn=DE_WriteEn=0.
  - When InstMemStall=0, the returning instruction is discarded and the next state is RUN. The PC already holds the target.
  - redir in PEND is handled as RUN rule 2.
  - Each PEND cycle counts StallCycles++.
- DRAIN: PCWriteEn=0, FD_Flush=1. The drain counter decrements on cycles with DataMemStall=0. When the counter is 1 and decrements, the next state is HALTED. DataMemStall cycles freeze D/E and the counter.
- HALTED: all enables 0, FD_Flush=DE_Flush=1, Halted=1. Sticky until rst. Counters frozen.
- Halt_D and redir in the same cycle: redir wins and the halt is flushed.
- Counters saturate at all-ones and do not wrap.

Test Plan:
- Load-use: MemRead_E=1, WriteRegEn_E=1, WriteReg_E=3, Rs_D=3, RsV_D=1 for one cycle -> PCWriteEn=0, FD_WriteEn=0, DE_Flush=1 for exactly 1 cycle; StallCycles 0->1. Repeat with RsV_D=0 -> no stall.
- Taken branch: BranchEF=1 for one cycle -> Redirect=1, FD_Flush=DE_Flush=1 that cycle, FlushCount=1.
- Redirect during fetch miss: BranchEF=1 with InstMemStall=1, then InstMemStall held 3 more cycles -> PEND. FD_Flush=1 and PCWriteEn=0 for those cycles plus the release cycle. Back to RUN; StallCycles=4.
- DataMemStall priority: DataMemStall=1 for 5 cycles with BranchEF=1 and loaduse true -> all enables 0, Redirect=0 throughout. After release, redirect fires once.
- Halt: Halt_D=1 -> Halted rises exactly 3 cycles later. Add 2 DataMemStall cycles during DRAIN -> Halted rises 5 cycles later. Halt_D together with Jump_E -> no halt, redirect taken.
- Reset mid-DRAIN and in HALTED -> next cycle is RUN, Halted=0, counters 0. Force StallCycles to 16'hFFFF, then stall again -> stays 16'hFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline stages and pipe_hazard_ctrl.
// master drives the hazard sources, slave returns the pipeline controls.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       Rs_D;
    logic             RsV_D;
    logic [2:0]       Rt_D;
    logic             RtV_D;
    logic             Halt_D;
    logic             MemRead_E;
    logic [2:0]       WriteReg_E;
    logic             WriteRegEn_E;
    logic             BranchEF;
    logic             Jump_E;
    logic             DataMemStall;
    logic             InstMemStall;
    logic             PCWriteEn;
    logic             Redirect;
    logic             FD_WriteEn;
    logic             FD_Flush;
    logic             DE_WriteEn;
    logic             DE_Flush;
    logic             Halted;
    logic [CNT_W-1:0] StallCycles;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        output Rs_D, RsV_D, Rt_D, RtV_D, Halt_D,
        output MemRead_E, WriteReg_E, WriteRegEn_E,
        output BranchEF, Jump_E, DataMemStall, InstMemStall,
        input  PCWriteEn, Redirect, FD_WriteEn, FD_Flush,
        input  DE_WriteEn, DE_Flush, Halted,
        input  StallCycles, FlushCount
    );

    modport slave (
        input  Rs_D, RsV_D, Rt_D, RtV_D, Halt_D,
        input  MemRead_E, WriteReg_E, WriteRegEn_E,
        input  BranchEF, Jump_E, DataMemStall, InstMemStall,
        output PCWriteEn, Redirect, FD_WriteEn, FD_Flush,
        output DE_WriteEn, DE_Flush, Halted,
        output StallCycles, FlushCount
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for PC, F/D and D/E with halt draining
// and saturating stall/redirect counters.
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);
    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN, PEND, DRAIN, HALTED
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             stall_inc, flush_inc;
    logic             redir, loaduse;
    logic             pc_we, fd_we, de_we, red, fdf, def, halted;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v,
        input logic             en
    );
        if (en && (v != {CNT_W{1'b1}}))
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        return v;
    endfunction

    always_comb begin
        redir   = hz.BranchEF | hz.Jump_E;
        loaduse = hz.MemRead_E & hz.WriteRegEn_E &
                  ((hz.RsV_D & (hz.Rs_D == hz.WriteReg_E)) |
                   (hz.RtV_D & (hz.Rt_D == hz.WriteReg_E)));
        pc_we     = 1'b1;
        fd_we     = 1'b1;
        de_we     = 1'b1;
        red       = 1'b0;
        fdf       = 1'b0;
        def       = 1'b0;
        halted    = 1'b0;
        state_d   = state_q;
        drain_d   = drain_q;
        stall_inc = 1'b0;
        flush_inc = 1'b0;

        unique case (state_q)
            RUN: begin
                if (hz.DataMemStall) begin
                    pc_we     = 1'b0;
                    fd_we     = 1'b0;
                    de_we     = 1'b0;
                    stall_inc = 1'b1;
                end else if (redir) begin
                    red       = 1'b1;
                    fdf       = 1'b1;
                    def       = 1'b1;
                    flush_inc = 1'b1;
                    if (hz.InstMemStall)
                        state_d = PEND;
                end else if (loaduse) begin
                    pc_we     = 1'b0;
                    fd_we     = 1'b0;
                    def       = 1'b1;
                    stall_inc = 1'b1;
                end else if (hz.InstMemStall) begin
                    pc_we     = 1'b0;
                    fdf       = 1'b1;
                    stall_inc = 1'b1;
                end else if (hz.Halt_D) begin
                    pc_we   = 1'b0;
                    fdf     = 1'b1;
                    drain_d = DW'(DRAIN_CYCLES);
                    state_d = DRAIN;
                end
            end
            PEND: begin
                // Wrong-path fetch still in flight: PC already holds the target.
                pc_we     = 1'b0;
                fdf       = 1'b1;
                stall_inc = 1'b1;
                if (hz.DataMemStall) begin
                    fd_we = 1'b0;
                    de_we = 1'b0;
                    if (!hz.InstMemStall)
                        state_d = RUN;
                end else if (redir) begin
                    pc_we     = 1'b1;
                    red       = 1'b1;
                    def       = 1'b1;
                    flush_inc = 1'b1;
                    state_d   = hz.InstMemStall ? PEND : RUN;
                end else if (!hz.InstMemStall) begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                pc_we = 1'b0;
                fdf   = 1'b1;
                if (hz.DataMemStall) begin
                    fd_we = 1'b0;
                    de_we = 1'b0;
                end else begin
                    drain_d = drain_q - DW'(1);
                    if (drain_q == DW'(1))
                        state_d = HALTED;
                end
            end
            HALTED: begin
                pc_we  = 1'b0;
                fd_we  = 1'b0;
                de_we  = 1'b0;
                fdf    = 1'b1;
                def    = 1'b1;
                halted = 1'b1;
            end
            default: state_d = RUN;
        endcase

        if (rst) begin
            pc_we     = 1'b0;
            fd_we     = 1'b0;
            de_we     = 1'b0;
            red       = 1'b0;
            fdf       = 1'b1;
            def       = 1'b1;
            halted    = 1'b0;
            state_d   = RUN;
            drain_d   = '0;
            stall_inc = 1'b0;
            flush_inc = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            drain_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= sat_inc(stall_q, stall_inc);
            flush_q <= sat_inc(flush_q, flush_inc);
        end
    end

    assign hz.PCWriteEn   = pc_we;
    assign hz.Redirect    = red;
    assign hz.FD_WriteEn  = fd_we;
    assign hz.FD_Flush    = fdf;
    assign hz.DE_WriteEn  = de_we;
    assign hz.DE_Flush    = def;
    assign hz.Halted      = halted;
    assign hz.StallCycles = stall_q;
    assign hz.FlushCount  = flush_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: stalls, redirects, drain,
// reset recovery and counter saturation.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    pipe_hazard_ctrl_if #(.CNT_W(16)) b ();

    pipe_hazard_ctrl #(
        .DRAIN_CYCLES(3),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz(b.slave)
    );

    always #5 clk = ~clk;

    // {PCWriteEn, Redirect, FD_WriteEn, FD_Flush, DE_WriteEn, DE_Flush, Halted}
    localparam logic [6:0] NORM  = 7'b1010100;
    localparam logic [6:0] RSTV  = 7'b0001010;
    localparam logic [6:0] FRZ   = 7'b0000000;
    localparam logic [6:0] REDIR = 7'b1111110;
    localparam logic [6:0] LU    = 7'b0000110;
    localparam logic [6:0] BUB   = 7'b0011100;
    localparam logic [6:0] BUBF  = 7'b0001000;
    localparam logic [6:0] HLT   = 7'b0001011;

    logic [6:0] ctl;
    assign ctl = {b.PCWriteEn, b.Redirect, b.FD_WriteEn, b.FD_Flush,
                  b.DE_WriteEn, b.DE_Flush, b.Halted};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b.Rs_D = 3'd0; b.RsV_D = 1'b0;
        b.Rt_D = 3'd0; b.RtV_D = 1'b0;
        b.Halt_D = 1'b0; b.MemRead_E = 1'b0;
        b.WriteReg_E = 3'd0; b.WriteRegEn_E = 1'b0;
        b.BranchEF = 1'b0; b.Jump_E = 1'b0;
        b.DataMemStall = 1'b0; b.InstMemStall = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== RSTV) begin
            errors++;
            $display("FAIL reset_ctl got=%b want=%b", ctl, RSTV);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== NORM || b.StallCycles !== 16'd0 || b.FlushCount !== 16'd0) begin
            errors++;
            $display("FAIL reset_run ctl=%b st=%0d fl=%0d want ctl=%b st=0 fl=0",
                     ctl, b.StallCycles, b.FlushCount, NORM);
        end
    endtask

    task automatic test_loaduse();
        do_reset();
        b.MemRead_E = 1'b1; b.WriteRegEn_E = 1'b1; b.WriteReg_E = 3'd3;
        b.Rs_D = 3'd3; b.RsV_D = 1'b1;
        #1;
        checks++;
        if (ctl !== LU) begin
            errors++;
            $display("FAIL loaduse_rs ctl got=%b want=%b", ctl, LU);
        end
        tick();
        idle();
        #1;
        checks++;
        if (ctl !== NORM || b.StallCycles !== 16'd1) begin
            errors++;
            $display("FAIL loaduse_after ctl=%b st=%0d want ctl=%b st=1",
                     ctl, b.StallCycles, NORM);
        end
        b.MemRead_E = 1'b1; b.WriteRegEn_E = 1'b1; b.WriteReg_E = 3'd3;
        b.Rs_D = 3'd3; b.RsV_D = 1'b0;
        #1;
        checks++;
        if (ctl !== NORM) begin
            errors++;
            $display("FAIL loaduse_invalid ctl got=%b want=%b", ctl, NORM);
        end
        tick();
        b.Rs_D = 3'd5; b.RsV_D = 1'b1; b.Rt_D = 3'd3; b.RtV_D = 1'b1;
        #1;
        checks++;
        if (ctl !== LU || b.StallCycles !== 16'd1) begin
            errors++;
            $display("FAIL loaduse_rt ctl=%b st=%0d want ctl=%b st=1",
                     ctl, b.StallCycles, LU);
        end
        tick();
        idle();
        #1;
        checks++;
        if (b.StallCycles !== 16'd2) begin
            errors++;
            $display("FAIL loaduse_count got=%0d want=2", b.StallCycles);
        end
    endtask

    task automatic test_branch();
        do_reset();
        b.BranchEF = 1'b1;
        #1;
        checks++;
        if (ctl !== REDIR) begin
            errors++;
            $display("FAIL branch_ctl got=%b want=%b", ctl, REDIR);
        end
        tick();
        idle();
        #1;
        checks++;
        if (ctl !== NORM || b.FlushCount !== 16'd1 || b.StallCycles !== 16'd0) begin
            errors++;
            $display("FAIL branch_after ctl=%b fl=%0d st=%0d want ctl=%b fl=1 st=0",
                     ctl, b.FlushCount, b.StallCycles, NORM);
        end
        b.Jump_E = 1'b1;
        #1;
        checks++;
        if (ctl !== REDIR) begin
            errors++;
            $display("FAIL jump_ctl got=%b want=%b", ctl, REDIR);
        end
        tick();
        idle();
        #1;
        checks++;
        if (b.FlushCount !== 16'd2) begin
            errors++;
            $display("FAIL jump_count got=%0d want=2", b.FlushCount);
        end
    endtask

    task automatic test_pend();
        do_reset();
        b.BranchEF = 1'b1; b.InstMemStall = 1'b1;
        #1;
        checks++;
        if (ctl !== REDIR) begin
            errors++;
            $display("FAIL pend_entry ctl got=%b want=%b", ctl, REDIR);
        end
        tick();
        b.BranchEF = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl !== BUB) begin
                errors++;
                $display("FAIL pend_hold%0d ctl got=%b want=%b", i, ctl, BUB);
            end
            tick();
        end
        b.InstMemStall = 1'b0;
        #1;
        checks++;
        if (ctl !== BUB) begin
            errors++;
            $display("FAIL pend_release ctl got=%b want=%b", ctl, BUB);
        end
        tick();
        #1;
        checks++;
        if (ctl !== NORM || b.StallCycles !== 16'd4 || b.FlushCount !== 16'd1) begin
            errors++;
            $display("FAIL pend_done ctl=%b st=%0d fl=%0d want ctl=%b st=4 fl=1",
                     ctl, b.StallCycles, b.FlushCount, NORM);
        end
    endtask

    task automatic test_dmem_priority();
        do_reset();
        b.DataMemStall = 1'b1; b.BranchEF = 1'b1;
        b.MemRead_E = 1'b1; b.WriteRegEn_E = 1'b1; b.WriteReg_E = 3'd2;
        b.Rs_D = 3'd2; b.RsV_D = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (ctl !== FRZ) begin
                errors++;
                $display("FAIL dms_freeze%0d ctl got=%b want=%b", i, ctl, FRZ);
            end
            tick();
        end
        b.DataMemStall = 1'b0;
        #1;
        checks++;
        if (ctl !== REDIR || b.FlushCount !== 16'd0) begin
            errors++;
            $display("FAIL dms_release ctl=%b fl=%0d want ctl=%b fl=0",
                     ctl, b.FlushCount, REDIR);
        end
        tick();
        idle();
        #1;
        checks++;
        if (ctl !== NORM || b.FlushCount !== 16'd1 || b.StallCycles !== 16'd5) begin
            errors++;
            $display("FAIL dms_done ctl=%b fl=%0d st=%0d want ctl=%b fl=1 st=5",
                     ctl, b.FlushCount, b.StallCycles, NORM);
        end
    endtask

    task automatic test_halt();
        do_reset();
        b.Halt_D = 1'b1;
        #1;
        checks++;
        if (ctl !== BUB) begin
            errors++;
            $display("FAIL halt_entry ctl got=%b want=%b", ctl, BUB);
        end
        tick();
        b.Halt_D = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl !== BUB) begin
                errors++;
                $display("FAIL halt_drain%0d ctl got=%b want=%b", i, ctl, BUB);
            end
            tick();
        end
        #1;
        checks++;
        if (ctl !== HLT) begin
            errors++;
            $display("FAIL halt_rise ctl got=%b want=%b", ctl, HLT);
        end
        b.BranchEF = 1'b1; b.InstMemStall = 1'b1;
        tick();
        tick();
        checks++;
        if (ctl !== HLT || b.StallCycles !== 16'd0 || b.FlushCount !== 16'd0) begin
            errors++;
            $display("FAIL halt_sticky ctl=%b st=%0d fl=%0d want ctl=%b st=0 fl=0",
                     ctl, b.StallCycles, b.FlushCount, HLT);
        end
    endtask

    task automatic test_halt_dms();
        do_reset();
        b.Halt_D = 1'b1;
        tick();
        b.Halt_D = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b.DataMemStall = (i == 1 || i == 2);
            #1;
            checks++;
            if (ctl !== (b.DataMemStall ? BUBF : BUB)) begin
                errors++;
                $display("FAIL halt_dms_drain%0d ctl got=%b want=%b", i, ctl,
                         b.DataMemStall ? BUBF : BUB);
            end
            tick();
        end
        b.DataMemStall = 1'b0;
        #1;
        checks++;
        if (ctl !== HLT) begin
            errors++;
            $display("FAIL halt_dms_rise ctl got=%b want=%b", ctl, HLT);
        end
    endtask

    task automatic test_halt_jump();
        do_reset();
        b.Halt_D = 1'b1; b.Jump_E = 1'b1;
        #1;
        checks++;
        if (ctl !== REDIR) begin
            errors++;
            $display("FAIL halt_jump_ctl got=%b want=%b", ctl, REDIR);
        end
        tick();
        idle();
        tick();
        tick();
        tick();
        tick();
        checks++;
        if (ctl !== NORM || b.FlushCount !== 16'd1) begin
            errors++;
            $display("FAIL halt_jump_after ctl=%b fl=%0d want ctl=%b fl=1",
                     ctl, b.FlushCount, NORM);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        b.InstMemStall = 1'b1;
        tick();
        tick();
        b.InstMemStall = 1'b0;
        b.Halt_D = 1'b1;
        tick();
        b.Halt_D = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== RSTV) begin
            errors++;
            $display("FAIL rst_drain_ctl got=%b want=%b", ctl, RSTV);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== NORM || b.StallCycles !== 16'd0) begin
            errors++;
            $display("FAIL rst_drain_after ctl=%b st=%0d want ctl=%b st=0",
                     ctl, b.StallCycles, NORM);
        end
        b.BranchEF = 1'b1;
        tick();
        b.BranchEF = 1'b0;
        b.Halt_D = 1'b1;
        tick();
        b.Halt_D = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== RSTV) begin
            errors++;
            $display("FAIL rst_halted_ctl got=%b want=%b", ctl, RSTV);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== NORM || b.FlushCount !== 16'd0) begin
            errors++;
            $display("FAIL rst_halted_after ctl=%b fl=%0d want ctl=%b fl=0",
                     ctl, b.FlushCount, NORM);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        b.InstMemStall = 1'b1;
        repeat (65534) tick();
        checks++;
        if (b.StallCycles !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_near got=%h want=fffe", b.StallCycles);
        end
        tick();
        checks++;
        if (b.StallCycles !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_top got=%h want=ffff", b.StallCycles);
        end
        repeat (3) tick();
        checks++;
        if (b.StallCycles !== 16'hFFFF || b.FlushCount !== 16'd0) begin
            errors++;
            $display("FAIL sat_hold st=%h fl=%h want st=ffff fl=0",
                     b.StallCycles, b.FlushCount);
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_loaduse();
        test_branch();
        test_pend();
        test_dmem_priority();
        test_halt();
        test_halt_dms();
        test_halt_jump();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
